// File: rtl/ex_muldiv_pkg.sv
// Shared op codes, FSM encoding and helpers for the ex_muldiv unit.
// EX_MULDIV_MADD_EN: when defined, MADD/MADDU/MSUB/MSUBU (codes 4..7) are legal accumulate ops.
package ex_muldiv_pkg;

    localparam logic [2:0] MD_OP_MULT  = 3'd0;
    localparam logic [2:0] MD_OP_MULTU = 3'd1;
    localparam logic [2:0] MD_OP_DIV   = 3'd2;
    localparam logic [2:0] MD_OP_DIVU  = 3'd3;
    localparam logic [2:0] MD_OP_MADD  = 3'd4;
    localparam logic [2:0] MD_OP_MADDU = 3'd5;
    localparam logic [2:0] MD_OP_MSUB  = 3'd6;
    localparam logic [2:0] MD_OP_MSUBU = 3'd7;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StFin} md_state_e;

    // Bit 0 of every op code selects unsigned operands.
    function automatic logic md_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes: one quotient bit per cycle, DATA_W cycles.
module ex_div_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic              clear,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              last,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

    logic              run_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] quo_q, rem_q, dvs_q;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;
    logic              unused_diff;

    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
    end

    // The partial remainder after a successful subtract is below the divisor.
    assign unused_diff = diff[DATA_W];
    assign last        = run_q && (cnt_q == LastCnt);
    assign quot        = quo_q;
    assign rem         = rem_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            run_q <= 1'b0;
            cnt_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (clear) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
        end else if (run_q) begin
            quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W+1]};
            rem_q <= diff[DATA_W+1] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit producing HI/LO pairs; stalls ex until done.
// Accumulate ops are enabled by defining EX_MULDIV_MADD_EN.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned CNT_W   = 6
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic [DATA_W-1:0] acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic              annul,
    output logic              busy,
    output logic              stall_req,
    output logic              done,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);
    localparam logic [CNT_W-1:0] MulBase = CNT_W'(MUL_LAT - 1);

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, mul_cyc_in, mul_cyc_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   opa_q, opb_q, res_hi_q, res_lo_q;
    logic                op_legal, is_idle, accept, div_start, div_last;
    logic                sgn, neg_q, neg_r;
    logic [DATA_W-1:0]   mag_a, mag_b, div_quot, div_rem;
    logic [2*DATA_W-1:0] a_ext, b_ext, prod, pend;

`ifdef EX_MULDIV_MADD_EN
    logic [2*DATA_W-1:0] acc_q;
    assign op_legal = 1'b1;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       acc_q <= '0;
        else if (accept) acc_q <= {acc_hi, acc_lo};
    end
`else
    logic unused_acc;
    assign op_legal   = ~op[2];
    assign unused_acc = ^{acc_hi, acc_lo};
`endif

    assign is_idle    = (state_q == StIdle);
    assign accept     = start & op_legal & ~annul & is_idle;
    assign div_start  = accept & md_is_div(op) & (opb != '0);
    // Accumulate ops spend one extra cycle in MUL.
    assign mul_cyc_in = MulBase + CNT_W'(op[2]);
    assign mul_cyc_q  = MulBase + CNT_W'(op_q[2]);

    assign mag_a = (~op[0] & opa[DATA_W-1]) ? -opa : opa;
    assign mag_b = (~op[0] & opb[DATA_W-1]) ? -opb : opb;

    ex_div_iter #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_div (
        .clk      (clk),
        .rst_     (rst_),
        .start    (div_start),
        .clear    (annul),
        .dividend (mag_a),
        .divisor  (mag_b),
        .last     (div_last),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d = '0;
                    if (md_is_div(op))           state_d = (opb == '0) ? StFin : StDiv;
                    else if (mul_cyc_in == '0)   state_d = StFin;
                    else                         state_d = StMul;
                end
            end
            StMul: begin
                if (cnt_q == mul_cyc_q - CNT_W'(1)) begin
                    state_d = StFin;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDiv:   if (div_last) state_d = StFin;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (annul && !is_idle) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    // Result from latched operands; the product is only consumed MUL_LAT cycles after latching.
    always_comb begin
        sgn   = ~op_q[0];
        a_ext = {{DATA_W{sgn & opa_q[DATA_W-1]}}, opa_q};
        b_ext = {{DATA_W{sgn & opb_q[DATA_W-1]}}, opb_q};
        prod  = a_ext * b_ext;
        neg_q = sgn & (opa_q[DATA_W-1] ^ opb_q[DATA_W-1]);
        neg_r = sgn & opa_q[DATA_W-1];
        pend  = prod;
        if (md_is_div(op_q)) begin
            if (opb_q == '0) pend = {opa_q, {DATA_W{1'b1}}};
            else             pend = {neg_r ? -div_rem : div_rem, neg_q ? -div_quot : div_quot};
        end
`ifdef EX_MULDIV_MADD_EN
        else if (op_q[2]) begin
            pend = op_q[1] ? (acc_q - prod) : (acc_q + prod);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= MD_OP_MULT;
            opa_q    <= '0;
            opb_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= op;
                opa_q <= opa;
                opb_q <= opb;
            end
            if (done) {res_hi_q, res_lo_q} <= pend;
        end
    end

    assign busy             = ~is_idle;
    assign done             = (state_q == StFin) & ~annul;
    assign stall_req        = (start & op_legal & is_idle) | (busy & ~done);
    assign {res_hi, res_lo} = done ? pend : {res_hi_q, res_lo_q};

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv (DATA_W=32, MUL_LAT=2).
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] opa = '0, opb = '0, acc_hi = '0, acc_lo = '0;
    logic        annul = 1'b0;
    logic        busy, stall_req, done;
    logic [31:0] res_hi, res_lo;

    int errors = 0;
    int checks = 0;

    ex_muldiv #(
        .DATA_W  (32),
        .MUL_LAT (2),
        .CNT_W   (6)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .start     (start),
        .op        (op),
        .opa       (opa),
        .opb       (opb),
        .acc_hi    (acc_hi),
        .acc_lo    (acc_lo),
        .annul     (annul),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always #5 clk = ~clk;

    // Issue one op, scramble inputs after acceptance, wait for done (lat=-1 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ah, input logic [31:0] al,
                          output int lat, output logic st0, output logic st1);
        @(posedge clk); #1;
        op = o; opa = a; opb = b; acc_hi = ah; acc_lo = al; start = 1'b1;
        #1 st0 = stall_req;
        @(posedge clk); #1;
        start = 1'b0; opa = $urandom; opb = $urandom; acc_hi = $urandom; acc_lo = $urandom;
        st1 = stall_req;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_req); end
        checks++; if ({res_hi, res_lo} !== 64'h0) begin errors++; $display("FAIL reset_res got %h want 0", {res_hi, res_lo}); end
        @(negedge clk); rst_ = 1'b1;
    endtask

    task automatic test_mult();
        int lat; logic s0, s1;
        run_op(3'd0, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, lat, s0, s1);
        checks++; if (lat !== 2) begin errors++; $display("FAIL mult_lat got %0d want 2", lat); end
        checks++; if (res_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", res_hi); end
        checks++; if (res_lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got %h want fffffffe", res_lo); end
        checks++; if ({s0, s1} !== 2'b11) begin errors++; $display("FAIL mult_stall got %b want 11", {s0, s1}); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mult_stall_done got %b want 0", stall_req); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
        checks++; if (res_lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_hold got %h want fffffffe", res_lo); end
    endtask

    task automatic test_multu();
        int lat; logic s0, s1;
        run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 32'h0, 32'h0, lat, s0, s1);
        checks++; if (lat !== 2) begin errors++; $display("FAIL multu_lat got %0d want 2", lat); end
        checks++; if ({res_hi, res_lo} !== 64'h1_FFFF_FFFE) begin errors++; $display("FAIL multu_res got %h want 00000001fffffffe", {res_hi, res_lo}); end
    endtask

    task automatic test_div_signed();
        int lat; logic s0, s1;
        run_op(3'd2, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, lat, s0, s1);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_lat got %0d want 33", lat); end
        checks++; if ({res_hi, res_lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg7_2 got %h want fffffffffffffffd", {res_hi, res_lo}); end
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, lat, s0, s1);
        checks++; if ({res_hi, res_lo} !== 64'h0_8000_0000) begin errors++; $display("FAIL div_minint got %h want 0000000080000000", {res_hi, res_lo}); end
        run_op(3'd2, 32'h7, 32'hFFFF_FFFE, 32'h0, 32'h0, lat, s0, s1);
        checks++; if ({res_hi, res_lo} !== 64'h1_FFFF_FFFD) begin errors++; $display("FAIL div_7_neg2 got %h want 00000001fffffffd", {res_hi, res_lo}); end
    endtask

    task automatic test_div_zero();
        int lat; logic s0, s1;
        run_op(3'd3, 32'h5, 32'h0, 32'h0, 32'h0, lat, s0, s1);
        checks++; if (lat !== 1) begin errors++; $display("FAIL divz_lat got %0d want 1", lat); end
        checks++; if ({res_hi, res_lo} !== 64'h5_FFFF_FFFF) begin errors++; $display("FAIL divz_res got %h want 00000005ffffffff", {res_hi, res_lo}); end
    endtask

    task automatic test_annul();
        int seen = 0; int lat; logic s0, s1;
        @(posedge clk); #1;
        op = 3'd3; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL annul_done got %b want 0", done); end
        @(posedge clk); #1;
        annul = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy got %b want 0", busy); end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL annul_no_done got %0d want 0", seen); end
        checks++; if ({res_hi, res_lo} !== 64'h5_FFFF_FFFF) begin errors++; $display("FAIL annul_res got %h want 00000005ffffffff", {res_hi, res_lo}); end
        run_op(3'd3, 32'd100, 32'd7, 32'h0, 32'h0, lat, s0, s1);
        checks++; if ({res_hi, res_lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL annul_redo got %h want 000000020000000e", {res_hi, res_lo}); end
    endtask

    task automatic test_back_to_back();
        int lat; logic s0, s1;
        run_op(3'd1, 32'd3, 32'd4, 32'h0, 32'h0, lat, s0, s1);
        checks++; if ({res_hi, res_lo} !== 64'd12) begin errors++; $display("FAIL b2b_mul got %h want 000000000000000c", {res_hi, res_lo}); end
        run_op(3'd3, 32'd9, 32'd2, 32'h0, 32'h0, lat, s0, s1);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_div_lat got %0d want 33", lat); end
        checks++; if ({res_hi, res_lo} !== {32'd1, 32'd4}) begin errors++; $display("FAIL b2b_div got %h want 0000000100000004", {res_hi, res_lo}); end
    endtask

    task automatic test_start_while_busy();
        int lat; logic s0, s1;
        fork
            run_op(3'd3, 32'd20, 32'd3, 32'h0, 32'h0, lat, s0, s1);
            begin
                repeat (5) @(posedge clk);
                #3 start = 1'b1; op = 3'd1;
                @(posedge clk); #3 start = 1'b0; op = 3'd3;
            end
        join
        checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_lat got %0d want 33", lat); end
        checks++; if ({res_hi, res_lo} !== {32'd2, 32'd6}) begin errors++; $display("FAIL busy_start_res got %h want 0000000200000006", {res_hi, res_lo}); end
    endtask

`ifdef EX_MULDIV_MADD_EN
    task automatic test_madd();
        int lat; logic s0, s1;
        run_op(3'd5, 32'd1, 32'd1, 32'h0, 32'hFFFF_FFFF, lat, s0, s1);
        checks++; if (lat !== 3) begin errors++; $display("FAIL maddu_lat got %0d want 3", lat); end
        checks++; if ({res_hi, res_lo} !== 64'h1_0000_0000) begin errors++; $display("FAIL maddu_res got %h want 0000000100000000", {res_hi, res_lo}); end
        run_op(3'd6, 32'd3, 32'd2, 32'h0, 32'd5, lat, s0, s1);
        checks++; if ({res_hi, res_lo} !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL msub_res got %h want ffffffffffffffff", {res_hi, res_lo}); end
    endtask
`else
    task automatic test_illegal();
        int seen = 0;
        @(posedge clk); #1;
        op = 3'd4; opa = 32'd1; opb = 32'd1; start = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL illegal_stall got %b want 0", stall_req); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b want 0", busy); end
        repeat (5) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL illegal_done got %0d want 0", seen); end
    endtask
`endif

    task automatic test_annul_start();
        @(posedge clk); #1;
        op = 3'd0; opa = 32'd2; opb = 32'd2; start = 1'b1; annul = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_start_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        op = 3'd3; opa = 32'd100; opb = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_ = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
        checks++; if ({res_hi, res_lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_res got %h want 0", {res_hi, res_lo}); end
        @(negedge clk); rst_ = 1'b1;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div_signed();
        test_div_zero();
        test_annul();
        test_back_to_back();
        test_start_while_busy();
`ifdef EX_MULDIV_MADD_EN
        test_madd();
`else
        test_illegal();
`endif
        test_annul_start();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
